// File: rtl/bv_tcam_rule_writer.sv
// Rule writer for the bit-vector TCAM: walks every BV SRAM word of one mode region
// and read-modify-writes bit idx according to the ternary rule match.
module bv_tcam_rule_writer #(
    parameter int unsigned STRIDE       = 4,
    parameter int unsigned MODE_WIDTH   = 2,
    parameter int unsigned RESULT_WIDTH = 32,
    parameter int unsigned SRAM_NUM     = 32,
    parameter int unsigned IDX_W        = $clog2(RESULT_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_val,
    output logic                         cfg_ready,
    input  logic                         cfg_op,
    input  logic [IDX_W-1:0]             cfg_rule_idx,
    input  logic [MODE_WIDTH-1:0]        cfg_mode,
    input  logic [STRIDE*SRAM_NUM-1:0]   cfg_value,
    input  logic [STRIDE*SRAM_NUM-1:0]   cfg_mask,
    output logic [7:0]                   sram_sel,
    output logic [STRIDE+MODE_WIDTH-1:0] config_addr,
    output logic                         rd_en,
    input  logic [RESULT_WIDTH-1:0]      rd_data,
    output logic                         config_en,
    output logic [RESULT_WIDTH-1:0]      config_i,
    output logic                         done
);

    localparam int unsigned KEY_W  = STRIDE * SRAM_NUM;
    localparam int unsigned ADDR_W = STRIDE + MODE_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_t;

    state_t                  state, state_nxt;
    logic                    op_q, op_nxt;
    logic [IDX_W-1:0]        idx_q, idx_nxt;
    logic [MODE_WIDTH-1:0]   mode_q, mode_nxt;
    logic [KEY_W-1:0]        value_q, value_nxt, mask_q, mask_nxt;
    logic                    ready_nxt, rd_en_nxt, config_en_nxt, done_nxt;
    logic [7:0]              sel_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [RESULT_WIDTH-1:0] data_nxt;

    logic [STRIDE-1:0]       nib;
    logic [STRIDE-1:0]       val_chunk, mask_chunk;
    logic                    match;
    logic                    accept;
    logic                    last_entry;
    logic [RESULT_WIDTH-1:0] merged;

    assign nib        = config_addr[STRIDE-1:0];
    assign val_chunk  = value_q[int'(sram_sel) * int'(STRIDE) +: STRIDE];
    assign mask_chunk = mask_q[int'(sram_sel) * int'(STRIDE) +: STRIDE];
    assign match      = ((nib ^ val_chunk) & mask_chunk) == '0;
    assign accept     = cfg_val & cfg_ready;
    assign last_entry = (sram_sel == 8'(SRAM_NUM - 1)) && (&nib);
    // Only bit idx changes; it is set solely for an insert whose key matches this entry.
    assign merged     = (rd_data & ~(RESULT_WIDTH'(1) << idx_q))
                      | (RESULT_WIDTH'(op_q & match) << idx_q);

    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        idx_nxt       = idx_q;
        mode_nxt      = mode_q;
        value_nxt     = value_q;
        mask_nxt      = mask_q;
        ready_nxt     = cfg_ready;
        rd_en_nxt     = 1'b0;
        config_en_nxt = 1'b0;
        done_nxt      = 1'b0;
        sel_nxt       = sram_sel;
        addr_nxt      = config_addr;
        data_nxt      = config_i;
        case (state)
            S_IDLE, S_FIN: begin
                if (accept) begin
                    op_nxt    = cfg_op;
                    idx_nxt   = cfg_rule_idx;
                    mode_nxt  = cfg_mode;
                    value_nxt = cfg_value;
                    mask_nxt  = cfg_mask;
                    sel_nxt   = 8'd0;
                    addr_nxt  = {cfg_mode, STRIDE'(0)};
                    ready_nxt = 1'b0;
                    rd_en_nxt = 1'b1;
                    state_nxt = S_RD;
                end else begin
                    ready_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RD: state_nxt = S_CAP;
            S_CAP: begin
                data_nxt      = merged;
                config_en_nxt = 1'b1;
                state_nxt     = S_WR;
            end
            S_WR: begin
                if (last_entry) begin
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = S_FIN;
                end else begin
                    if (&nib) begin
                        sel_nxt  = sram_sel + 8'd1;
                        addr_nxt = {mode_q, STRIDE'(0)};
                    end else begin
                        addr_nxt = {mode_q, nib + STRIDE'(1)};
                    end
                    rd_en_nxt = 1'b1;
                    state_nxt = S_RD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= 1'b0;
            idx_q       <= '0;
            mode_q      <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            cfg_ready   <= 1'b1;
            rd_en       <= 1'b0;
            config_en   <= 1'b0;
            done        <= 1'b0;
            sram_sel    <= '0;
            config_addr <= '0;
            config_i    <= '0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            idx_q       <= idx_nxt;
            mode_q      <= mode_nxt;
            value_q     <= value_nxt;
            mask_q      <= mask_nxt;
            cfg_ready   <= ready_nxt;
            rd_en       <= rd_en_nxt;
            config_en   <= config_en_nxt;
            done        <= done_nxt;
            sram_sel    <= sel_nxt;
            config_addr <= addr_nxt;
            config_i    <= data_nxt;
        end
    end

endmodule

// File: tb/tb_bv_tcam_rule_writer.sv
// Directed bench for bv_tcam_rule_writer with a behavioural BV SRAM array.
module tb_bv_tcam_rule_writer;

    localparam int unsigned STRIDE = 4;
    localparam int unsigned MW     = 2;
    localparam int unsigned RW     = 32;
    localparam int unsigned SN     = 32;
    localparam int unsigned IW     = 5;
    localparam int unsigned KW     = STRIDE * SN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_val = 1'b0;
    logic              cfg_ready;
    logic              cfg_op = 1'b0;
    logic [IW-1:0]     cfg_rule_idx = '0;
    logic [MW-1:0]     cfg_mode = '0;
    logic [KW-1:0]     cfg_value = '0;
    logic [KW-1:0]     cfg_mask = '0;
    logic [7:0]        sram_sel;
    logic [STRIDE+MW-1:0] config_addr;
    logic              rd_en;
    logic [RW-1:0]     rd_data = '0;
    logic              config_en;
    logic [RW-1:0]     config_i;
    logic              done;

    bv_tcam_rule_writer dut (
        .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_ready(cfg_ready),
        .cfg_op(cfg_op), .cfg_rule_idx(cfg_rule_idx), .cfg_mode(cfg_mode),
        .cfg_value(cfg_value), .cfg_mask(cfg_mask), .sram_sel(sram_sel),
        .config_addr(config_addr), .rd_en(rd_en), .rd_data(rd_data),
        .config_en(config_en), .config_i(config_i), .done(done)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] mem [SN][64];
    logic          preset_go = 1'b0;
    logic [RW-1:0] preset_val = '0;
    int ec = 0, acc_ec = 0;
    int rd_cyc = 0, wr_cyc = 0, done_cyc = 0, ndone = 0, nwr = 0;
    int bad_addr = 0, ovl = 0, rdy_err = 0, max_sel = 0;
    logic [MW-1:0] mode_exp = '0;
    int n_chk = 0, n_pass = 0;

    // SRAM model plus walk bookkeeping, all relative to the latest accept edge
    always @(posedge clk) begin
        ec <= ec + 1;
        if (preset_go) begin
            for (int s = 0; s < int'(SN); s++)
                for (int a = 0; a < 64; a++) mem[s][a] <= preset_val;
        end else if (!rst) begin
            if (rd_en) rd_data <= mem[sram_sel][config_addr];
            if (config_en) mem[sram_sel][config_addr] <= config_i;
            if (cfg_val && cfg_ready) begin
                acc_ec <= ec; rd_cyc <= 0; wr_cyc <= 0; done_cyc <= 0; ndone <= 0;
                nwr <= 0; bad_addr <= 0; ovl <= 0; rdy_err <= 0; max_sel <= 0;
                mode_exp <= cfg_mode;
            end else begin
                if (rd_en && rd_cyc == 0) rd_cyc <= ec - acc_ec;
                if (config_en) begin
                    if (wr_cyc == 0) wr_cyc <= ec - acc_ec;
                    nwr <= nwr + 1;
                    if (config_addr[5:4] != mode_exp) bad_addr <= bad_addr + 1;
                    if (int'(sram_sel) > max_sel) max_sel <= int'(sram_sel);
                end
                if (rd_en && config_en) ovl <= ovl + 1;
                if (done) begin
                    ndone <= ndone + 1;
                    if (done_cyc == 0) done_cyc <= ec - acc_ec;
                end
                if (cfg_ready && (ec - acc_ec) >= 1 && (ec - acc_ec) <= 1536)
                    rdy_err <= rdy_err + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic preset(input logic [RW-1:0] v);
        @(negedge clk); preset_val = v; preset_go = 1'b1;
        @(negedge clk); preset_go = 1'b0;
    endtask

    task automatic request(input logic op, input logic [IW-1:0] idx, input logic [MW-1:0] mode,
                           input logic [KW-1:0] value, input logic [KW-1:0] mask, input bit inject);
        @(negedge clk);
        cfg_val = 1'b1; cfg_op = op; cfg_rule_idx = idx; cfg_mode = mode;
        cfg_value = value; cfg_mask = mask;
        @(negedge clk); cfg_val = 1'b0;
        if (inject) begin
            repeat (99) @(negedge clk);
            cfg_val = 1'b1; cfg_rule_idx = idx + IW'(2); cfg_op = ~op; cfg_mode = ~mode;
            @(negedge clk); cfg_val = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 2000 && ndone == 0; k++) @(negedge clk);
        check({tag, "_done_seen"}, 64'(ndone), 64'd1);
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'd1537);
        check({tag, "_nwr"}, 64'(nwr), 64'd512);
        check({tag, "_bad_addr"}, 64'(bad_addr), 64'd0);
        check({tag, "_overlap"}, 64'(ovl), 64'd0);
    endtask

    int errs;
    logic [RW-1:0] e;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_config_en", 64'(config_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_outs", {24'd0, sram_sel, 2'd0, config_addr, config_i}, 64'd0);
        rst = 1'b0;

        // insert idx5 mode1, only SRAM0 cares (key 0xA)
        preset(32'h0);
        request(1'b1, 5'd5, 2'd1, KW'(128'hA), KW'(128'hF), 1'b0);
        wait_done("ins5");
        check("ins5_rd_cyc", 64'(rd_cyc), 64'd1);
        check("ins5_wr_cyc", 64'(wr_cyc), 64'd3);
        check("ins5_max_sel", 64'(max_sel), 64'd31);
        check("ins5_rdy_low", 64'(rdy_err), 64'd0);
        check("ins5_s0_1a", 64'(mem[0][6'h1A]), 64'h20);
        check("ins5_s0_10", 64'(mem[0][6'h10]), 64'h0);
        check("ins5_s31_1f", 64'(mem[31][6'h1F]), 64'h20);
        errs = 0;
        for (int s = 0; s < int'(SN); s++)
            for (int a = 0; a < 64; a++) begin
                e = 32'h0;
                if (a >= 16 && a < 32 && (s != 0 || a == 'h1A)) e = 32'h20;
                if (mem[s][a] !== e) errs++;
            end
        check("ins5_all", 64'(errs), 64'd0);

        // delete idx31 in mode2 over all-ones words
        preset(32'hFFFF_FFFF);
        request(1'b0, 5'd31, 2'd2, '1, '1, 1'b0);
        wait_done("del31");
        errs = 0;
        for (int s = 0; s < int'(SN); s++)
            for (int a = 0; a < 64; a++) begin
                e = (a >= 'h20 && a < 'h30) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
                if (mem[s][a] !== e) errs++;
            end
        check("del31_all", 64'(errs), 64'd0);

        // insert idx0, exact key 0x3 in every SRAM, mode3
        preset(32'h0000_FF00);
        request(1'b1, 5'd0, 2'd3, {SN{4'h3}}, '1, 1'b0);
        wait_done("ins0");
        check("ins0_s7_33", 64'(mem[7][6'h33]), 64'h0000_FF01);
        check("ins0_s7_32", 64'(mem[7][6'h32]), 64'h0000_FF00);
        errs = 0;
        for (int s = 0; s < int'(SN); s++)
            for (int a = 0; a < 64; a++) begin
                e = (a == 'h33) ? 32'h0000_FF01 : 32'h0000_FF00;
                if (mem[s][a] !== e) errs++;
            end
        check("ins0_all", 64'(errs), 64'd0);

        // second request during the walk must be ignored
        preset(32'h0);
        request(1'b1, 5'd5, 2'd1, KW'(128'hA), KW'(128'hF), 1'b1);
        wait_done("busy");
        check("busy_rdy_low", 64'(rdy_err), 64'd0);
        errs = 0;
        for (int s = 0; s < int'(SN); s++)
            for (int a = 0; a < 64; a++) begin
                e = 32'h0;
                if (a >= 16 && a < 32 && (s != 0 || a == 'h1A)) e = 32'h20;
                if (mem[s][a] !== e) errs++;
            end
        check("busy_all", 64'(errs), 64'd0);
        repeat (5) @(negedge clk);
        check("busy_no_rerun", 64'(nwr), 64'd512);

        // reset at cycle 700 aborts the walk
        preset(32'hFFFF_FFFF);
        request(1'b0, 5'd31, 2'd2, '1, '1, 1'b0);
        repeat (699) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_strobes", {61'd0, rd_en, config_en, done}, 64'd0);
        check("mid_rst_ready", 64'(cfg_ready), 64'd1);
        check("mid_rst_outs", {24'd0, sram_sel, 2'd0, config_addr, config_i}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", 64'(ndone), 64'd0);
        check("mid_rst_no_wr", 64'(config_en | rd_en), 64'd0);
        request(1'b0, 5'd31, 2'd2, '1, '1, 1'b0);
        wait_done("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
